// File: rtl/mem_pkg.sv
// Shared types for the core-side memory initiator: access sizes, FSM states, word geometry.
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } mem_state_e;

    // Size code 11 is an alias for a full word.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? MEM_WORD : sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == MEM_HALF) && (off == 2'd3)) || ((sz == MEM_WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: load extraction with sign/zero extension, and sub-word merge into an old word.
// Purely combinational, no latency, no flow control.
module mem_lane_align #(
    parameter int BITSIZE = 32
) (
    input  logic [1:0]         offset_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    input  logic [BITSIZE-1:0] rd_word_i,
    input  logic [BITSIZE-1:0] wdata_i,
    output logic [BITSIZE-1:0] ld_data_o,
    output logic [BITSIZE-1:0] st_word_o
);
    import mem_pkg::*;

    localparam int LANES = BITSIZE / 8;

    logic [BITSIZE-1:0] shifted;
    int                 n_bytes;

    always_comb begin
        shifted = rd_word_i >> {offset_i, 3'b000};
        case (size_i)
            MEM_BYTE: ld_data_o = {{(BITSIZE-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
            MEM_HALF: ld_data_o = {{(BITSIZE-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
            default:  ld_data_o = shifted;
        endcase
    end

    // New data is right-aligned; lane i of the word takes byte (i - offset) of it.
    always_comb begin
        case (size_i)
            MEM_BYTE: n_bytes = 1;
            MEM_HALF: n_bytes = 2;
            default:  n_bytes = LANES;
        endcase
        st_word_o = rd_word_i;
        for (int i = 0; i < LANES; i++) begin
            if ((i >= int'(offset_i)) && (i < int'(offset_i) + n_bytes)) begin
                st_word_o[8*i +: 8] = wdata_i[8*(i - int'(offset_i)) +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Core-side load/store initiator with lane extraction and read-modify-write for offset sub-word stores.
// Latency: 2 cycles accept->resp (3 for RMW, 1 for misaligned); waits on mem_valid_i, ready_o only in IDLE.
// Optional watchdog under MEM_TIMEOUT_EN aborts a memory phase after TIMEOUT_CYCLES without acknowledge.
module mem_initiator #(
    parameter int BITSIZE        = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [BITSIZE-1:0]    wdata_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic                  ready_o,
    output logic                  resp_valid_o,
    output logic [BITSIZE-1:0]    rdata_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BITSIZE-1:0]    mem_data_o,
    input  logic [BITSIZE-1:0]    mem_data_i,
    output logic                  mem_write_o,
    output logic [1:0]            mem_write_size_o,
    output logic                  mem_valid_o,
    input  logic                  mem_valid_i
);
    import mem_pkg::*;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] RD     = ST_RD;
    localparam logic [2:0] WR     = ST_WR;
    localparam logic [2:0] RMW_RD = ST_RMW_RD;
    localparam logic [2:0] RMW_WR = ST_RMW_WR;

    logic [2:0]            state_q, state_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BITSIZE-1:0]    mem_data_q, mem_data_d;
    logic [1:0]            mem_size_q, mem_size_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  err_q, err_d;
    logic [BITSIZE-1:0]    rdata_q, rdata_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic                  uns_q, uns_d;
    logic [BITSIZE-1:0]    wdata_q, wdata_d;

    logic [1:0]            req_size;
    logic [1:0]            req_off;
    logic                  req_mis;
    logic [BITSIZE-1:0]    ld_data;
    logic [BITSIZE-1:0]    st_word;
    logic                  tmo_hit;

    assign req_size = norm_size(size_i);
    assign req_off  = addr_i[1:0];
    assign req_mis  = is_misaligned(req_size, req_off);

    mem_lane_align #(.BITSIZE(BITSIZE)) u_align (
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rd_word_i  (mem_data_i),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if ((state_q != IDLE) && !mem_valid_i) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q != IDLE) && !mem_valid_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_size_d   = mem_size_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rdata_d      = '0;

        if (tmo_hit) begin
            // A stalled RMW read never reaches its write phase.
            state_d      = IDLE;
            mem_valid_d  = 1'b0;
            mem_write_d  = 1'b0;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        size_d     = req_size;
                        off_d      = req_off;
                        uns_d      = unsigned_i;
                        wdata_d    = wdata_i;
                        mem_addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        if (req_mis) begin
                            resp_valid_d = 1'b1;
                            err_d        = 1'b1;
                        end else if (!we_i) begin
                            state_d     = RD;
                            mem_valid_d = 1'b1;
                            mem_write_d = 1'b0;
                            mem_size_d  = MEM_WORD;
                        end else if (req_off == 2'd0) begin
                            state_d     = WR;
                            mem_valid_d = 1'b1;
                            mem_write_d = 1'b1;
                            mem_size_d  = req_size;
                            mem_data_d  = wdata_i;
                        end else begin
                            state_d     = RMW_RD;
                            mem_valid_d = 1'b1;
                            mem_write_d = 1'b0;
                            mem_size_d  = MEM_WORD;
                        end
                    end
                end
                RD: begin
                    if (mem_valid_i) begin
                        state_d      = IDLE;
                        mem_valid_d  = 1'b0;
                        resp_valid_d = 1'b1;
                        rdata_d      = ld_data;
                    end
                end
                // Valid stays high across the read->write hand-over; only the direction flips.
                RMW_RD: begin
                    if (mem_valid_i) begin
                        state_d     = RMW_WR;
                        mem_write_d = 1'b1;
                        mem_data_d  = st_word;
                        mem_size_d  = MEM_WORD;
                    end
                end
                WR, RMW_WR: begin
                    if (mem_valid_i) begin
                        state_d      = IDLE;
                        mem_valid_d  = 1'b0;
                        mem_write_d  = 1'b0;
                        resp_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    mem_write_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_size_q   <= 2'b00;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_size_q   <= mem_size_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
        end
    end

    assign ready_o          = (state_q == IDLE);
    assign resp_valid_o     = resp_valid_q;
    assign err_o            = err_q;
    assign rdata_o          = rdata_q;
    assign mem_valid_o      = mem_valid_q;
    assign mem_write_o      = mem_write_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_data_o       = mem_data_q;
    assign mem_write_size_o = mem_size_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: combinational word memory with optional wait states, scoreboarded responses.
module tb_mem_initiator;

    logic        clk;
    logic        resetn_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        ready_o;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_write_o;
    logic [1:0]  mem_write_size_o;
    logic        mem_valid_o;
    logic        mem_valid_i;

    mem_initiator dut (
        .clk              (clk),
        .resetn_i         (resetn_i),
        .req_i            (req_i),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .size_i           (size_i),
        .unsigned_i       (unsigned_i),
        .ready_o          (ready_o),
        .resp_valid_o     (resp_valid_o),
        .rdata_o          (rdata_o),
        .err_o            (err_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_data_i       (mem_data_i),
        .mem_write_o      (mem_write_o),
        .mem_write_size_o (mem_write_size_o),
        .mem_valid_o      (mem_valid_o),
        .mem_valid_i      (mem_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model: writes land from the word-aligned base only.
    logic [31:0] mem [0:63];
    int          wait_cfg = 0;
    int          ws_cnt = 0;
    bit          tie0 = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          vld_cycles = 0;
    int          stab_err = 0;
    logic [1:0]  last_wsize = 2'b00;
    logic [31:0] last_wdata = 32'h0;
    logic        tb_we = 1'b0;
    logic [31:0] tb_addr = 32'h0;
    logic [31:0] tb_data = 32'h0;
    logic        pend = 1'b0;
    logic [67:0] snap = '0;

    assign mem_valid_i = mem_valid_o && !tie0 && (ws_cnt >= wait_cfg);
    assign mem_data_i  = mem[mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr[7:2]] <= tb_data;
        if (mem_valid_o) vld_cycles <= vld_cycles + 1;
        if (mem_valid_o && mem_valid_i) begin
            ws_cnt <= 0;
            if (mem_write_o) begin
                n_wr       <= n_wr + 1;
                last_wsize <= mem_write_size_o;
                last_wdata <= mem_data_o;
                case (mem_write_size_o)
                    2'b00:   mem[mem_addr_o[7:2]][7:0]  <= mem_data_o[7:0];
                    2'b01:   mem[mem_addr_o[7:2]][15:0] <= mem_data_o[15:0];
                    default: mem[mem_addr_o[7:2]]       <= mem_data_o;
                endcase
            end else begin
                n_rd <= n_rd + 1;
            end
        end else if (mem_valid_o) begin
            ws_cnt <= ws_cnt + 1;
        end else begin
            ws_cnt <= 0;
        end
        if (pend && resetn_i && !tie0 &&
            ({mem_valid_o, mem_write_o, mem_write_size_o, mem_addr_o, mem_data_o} !== snap))
            stab_err <= stab_err + 1;
        pend <= mem_valid_o && !mem_valid_i;
        snap <= {mem_valid_o, mem_write_o, mem_write_size_o, mem_addr_o, mem_data_o};
    end

    typedef struct { logic [31:0] rdata; bit err; int lat; } exp_t;
    typedef struct { logic [31:0] addr; logic [1:0] sz; bit uns; logic [31:0] rdata; bit err; int lat; } ld_t;
    typedef struct {
        logic [31:0] addr; logic [31:0] wdata; logic [1:0] sz; bit err; int lat;
        int rds; int wrs; logic [1:0] wsize; logic [31:0] wword; logic [31:0] memw;
    } st_t;

    exp_t sbq[$];

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Drives one request and reports the response; latency counts cycles after the accepting edge.
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input bit uns, output logic [31:0] rd, output bit er, output int lat, output bit seen);
        int k;
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; size_i = sz; unsigned_i = uns;
        @(posedge clk);
        seen = 1'b0; lat = 0; rd = 32'h0; er = 1'b0; k = 0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) req_i = 1'b0;
            if (resp_valid_o) begin
                seen = 1'b1; lat = k; rd = rdata_o; er = err_o;
            end
        end
    endtask

    task automatic test_reset;
        resetn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = '0; unsigned_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++;
        if ({resp_valid_o, err_o, mem_valid_o, mem_write_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0000", {resp_valid_o, err_o, mem_valid_o, mem_write_o});
        end
        checks++;
        if ({rdata_o, mem_addr_o, mem_data_o, mem_write_size_o} !== 98'h0) begin
            failures++; $display("FAIL reset_data: rdata %h addr %h data %h size %b expected all zero",
                                 rdata_o, mem_addr_o, mem_data_o, mem_write_size_o);
        end
        resetn_i = 1'b1;
    endtask

    task automatic test_loads;
        ld_t lds[$];
        logic [31:0] rd; bit er, seen; int lat, rd0, v0;
        exp_t e;
        lds.push_back('{32'h11, 2'b00, 1'b0, 32'hFFFF_FFAA, 1'b0, 2});
        lds.push_back('{32'h12, 2'b01, 1'b1, 32'h0000_8899, 1'b0, 2});
        lds.push_back('{32'h10, 2'b00, 1'b1, 32'h0000_00BB, 1'b0, 2});
        lds.push_back('{32'h12, 2'b00, 1'b0, 32'hFFFF_FF99, 1'b0, 2});
        lds.push_back('{32'h10, 2'b01, 1'b0, 32'hFFFF_AABB, 1'b0, 2});
        lds.push_back('{32'h11, 2'b01, 1'b0, 32'hFFFF_99AA, 1'b0, 2});
        lds.push_back('{32'h13, 2'b00, 1'b1, 32'h0000_0088, 1'b0, 2});
        lds.push_back('{32'h10, 2'b10, 1'b0, 32'h8899_AABB, 1'b0, 2});
        lds.push_back('{32'h10, 2'b11, 1'b1, 32'h8899_AABB, 1'b0, 2});
        lds.push_back('{32'h21, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 2});
        lds.push_back('{32'h20, 2'b00, 1'b0, 32'h0000_007F, 1'b0, 2});
        lds.push_back('{32'h22, 2'b01, 1'b0, 32'h0000_7F00, 1'b0, 2});
        lds.push_back('{32'h16, 2'b10, 1'b0, 32'h0000_0000, 1'b1, 1});
        lds.push_back('{32'h13, 2'b01, 1'b1, 32'h0000_0000, 1'b1, 1});
        for (int i = 0; i < lds.size(); i++) begin
            sbq.push_back('{lds[i].rdata, lds[i].err, lds[i].lat});
            rd0 = n_rd; v0 = vld_cycles;
            issue(1'b0, lds[i].addr, 32'h0, lds[i].sz, lds[i].uns, rd, er, lat, seen);
            e = sbq.pop_front();
            checks++;
            if (!seen) begin failures++; $display("FAIL ld[%0d] no response within bound", i); end
            else begin
                checks++;
                if (rd !== e.rdata) begin failures++; $display("FAIL ld[%0d] rdata: got %h expected %h", i, rd, e.rdata); end
                checks++;
                if (er !== e.err) begin failures++; $display("FAIL ld[%0d] err: got %b expected %b", i, er, e.err); end
                checks++;
                if (lat !== e.lat) begin failures++; $display("FAIL ld[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
                checks++;
                if ((n_rd - rd0) !== (e.err ? 0 : 1)) begin
                    failures++; $display("FAIL ld[%0d] reads: got %0d expected %0d", i, n_rd - rd0, e.err ? 0 : 1);
                end
                if (e.err) begin
                    checks++;
                    if (vld_cycles !== v0) begin failures++; $display("FAIL ld[%0d] mem_valid on error: got %0d cycles expected 0", i, vld_cycles - v0); end
                end
            end
        end
    endtask

    task automatic test_stores;
        st_t sts[$];
        logic [31:0] rd; bit er, seen; int lat, rd0, wr0;
        exp_t e;
        sts.push_back('{32'h13, 32'h0000_005A, 2'b00, 1'b0, 3, 1, 1, 2'b10, 32'h5A99_AABB, 32'h5A99_AABB});
        sts.push_back('{32'h14, 32'hDEAD_BEEF, 2'b10, 1'b0, 2, 0, 1, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        sts.push_back('{32'h11, 32'hFFFF_1234, 2'b01, 1'b0, 3, 1, 1, 2'b10, 32'h5A12_34BB, 32'h5A12_34BB});
        sts.push_back('{32'h18, 32'hFFFF_CAFE, 2'b01, 1'b0, 2, 0, 1, 2'b01, 32'hFFFF_CAFE, 32'h1122_CAFE});
        sts.push_back('{32'h18, 32'h0000_AB77, 2'b00, 1'b0, 2, 0, 1, 2'b00, 32'h0000_AB77, 32'h1122_CA77});
        sts.push_back('{32'h1A, 32'h0000_000F, 2'b00, 1'b0, 3, 1, 1, 2'b10, 32'h110F_CA77, 32'h110F_CA77});
        sts.push_back('{32'h1B, 32'h0000_BEEF, 2'b01, 1'b1, 1, 0, 0, 2'b00, 32'h0,         32'h110F_CA77});
        sts.push_back('{32'h15, 32'h0000_0001, 2'b11, 1'b1, 1, 0, 0, 2'b00, 32'h0,         32'hDEAD_BEEF});
        for (int i = 0; i < sts.size(); i++) begin
            sbq.push_back('{32'h0, sts[i].err, sts[i].lat});
            rd0 = n_rd; wr0 = n_wr;
            issue(1'b1, sts[i].addr, sts[i].wdata, sts[i].sz, 1'b0, rd, er, lat, seen);
            e = sbq.pop_front();
            checks++;
            if (!seen) begin failures++; $display("FAIL st[%0d] no response within bound", i); end
            else begin
                checks++;
                if ({er, rd} !== {e.err, e.rdata}) begin failures++; $display("FAIL st[%0d] err/rdata: got %b/%h expected %b/%h", i, er, rd, e.err, e.rdata); end
                checks++;
                if (lat !== e.lat) begin failures++; $display("FAIL st[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
                checks++;
                if ((n_rd - rd0) !== sts[i].rds || (n_wr - wr0) !== sts[i].wrs) begin
                    failures++; $display("FAIL st[%0d] accesses: got rd %0d wr %0d expected rd %0d wr %0d",
                                         i, n_rd - rd0, n_wr - wr0, sts[i].rds, sts[i].wrs);
                end
                if (!sts[i].err) begin
                    checks++;
                    if (last_wsize !== sts[i].wsize || last_wdata !== sts[i].wword) begin
                        failures++; $display("FAIL st[%0d] write: got size %b data %h expected size %b data %h",
                                             i, last_wsize, last_wdata, sts[i].wsize, sts[i].wword);
                    end
                end
                checks++;
                if (mem[sts[i].addr[7:2]] !== sts[i].memw) begin
                    failures++; $display("FAIL st[%0d] memory: got %h expected %h", i, mem[sts[i].addr[7:2]], sts[i].memw);
                end
            end
        end
        sbq.push_back('{32'hDEAD_BEEF, 1'b0, 2});
        issue(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, rd, er, lat, seen);
        e = sbq.pop_front();
        checks++;
        if (!seen || rd !== e.rdata || lat !== e.lat) begin
            failures++; $display("FAIL readback_0x14: seen %b got %h lat %0d expected %h lat %0d", seen, rd, lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; bit er, seen; int lat;
        exp_t e;
        wait_cfg = 3;
        sbq.push_back('{32'h5A12_34BB, 1'b0, 5});
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, seen);
        e = sbq.pop_front();
        checks++;
        if (!seen || rd !== e.rdata || lat !== e.lat) begin
            failures++; $display("FAIL wait_load: seen %b got %h lat %0d expected %h lat %0d", seen, rd, lat, e.rdata, e.lat);
        end
        sbq.push_back('{32'h0, 1'b0, 9});
        issue(1'b1, 32'h12, 32'h0000_00EE, 2'b00, 1'b0, rd, er, lat, seen);
        e = sbq.pop_front();
        checks++;
        if (!seen || er !== e.err || lat !== e.lat) begin
            failures++; $display("FAIL wait_rmw: seen %b err %b lat %0d expected err %b lat %0d", seen, er, lat, e.err, e.lat);
        end
        checks++;
        if (mem[4] !== 32'h5AEE_34BB) begin failures++; $display("FAIL wait_rmw_mem: got %h expected 5aee34bb", mem[4]); end
        checks++;
        if (stab_err !== 0) begin failures++; $display("FAIL mem_stability: got %0d changes expected 0", stab_err); end
        wait_cfg = 0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h11; size_i = 2'b00; unsigned_i = 1'b0;
        sbq.push_back('{32'h0000_0034, 1'b0, 2});
        sbq.push_back('{32'hFFFF_FFEE, 1'b0, 4});
        @(posedge clk);
        @(negedge clk);
        addr_i = 32'h12;
        @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (resp_valid_o !== 1'b1 || rdata_o !== e.rdata || ready_o !== 1'b1) begin
            failures++; $display("FAIL b2b_first: resp %b rdata %h ready %b expected 1 %h 1", resp_valid_o, rdata_o, ready_o, e.rdata);
        end
        @(negedge clk);
        req_i = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_gap: resp %b expected 0", resp_valid_o); end
        @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (resp_valid_o !== 1'b1 || rdata_o !== e.rdata || err_o !== 1'b0) begin
            failures++; $display("FAIL b2b_second: resp %b rdata %h err %b expected 1 %h 0", resp_valid_o, rdata_o, err_o, e.rdata);
        end
    endtask

    task automatic test_reset_mid;
        int wr0, resp_seen;
        logic [31:0] rd; bit er, seen; int lat;
        exp_t e;
        wr0 = n_wr; resp_seen = 0;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h11; wdata_i = 32'h99; size_i = 2'b00;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        checks++;
        if (mem_valid_o !== 1'b1 || mem_write_o !== 1'b0) begin
            failures++; $display("FAIL rst_mid_rmw_rd: valid %b write %b expected 1 0", mem_valid_o, mem_write_o);
        end
        resetn_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", mem_valid_o); end
        resetn_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid_o) resp_seen++;
        end
        checks++;
        if (resp_seen !== 0 || n_wr !== wr0) begin
            failures++; $display("FAIL rst_mid_quiet: resp %0d writes %0d expected 0 0", resp_seen, n_wr - wr0);
        end
        checks++;
        if (mem[4] !== 32'h5AEE_34BB || ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_mid_mem: got %h ready %b expected 5aee34bb 1", mem[4], ready_o);
        end
        sbq.push_back('{32'h5AEE_34BB, 1'b0, 2});
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, seen);
        e = sbq.pop_front();
        checks++;
        if (!seen || rd !== e.rdata || lat !== e.lat) begin
            failures++; $display("FAIL rst_mid_recover: seen %b got %h lat %0d expected %h %0d", seen, rd, lat, e.rdata, e.lat);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] rd; bit er, seen; int lat, wr0;
        exp_t e;
        tie0 = 1'b1;
        sbq.push_back('{32'h0, 1'b1, 17});
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, seen);
        e = sbq.pop_front();
        checks++;
        if (!seen || er !== e.err || rd !== e.rdata || lat !== e.lat || mem_valid_o !== 1'b0) begin
            failures++; $display("FAIL timeout_load: seen %b err %b rdata %h lat %0d valid %b expected err 1 lat %0d",
                                 seen, er, rd, lat, mem_valid_o, e.lat);
        end
        wr0 = n_wr;
        sbq.push_back('{32'h0, 1'b1, 17});
        issue(1'b1, 32'h11, 32'h55, 2'b00, 1'b0, rd, er, lat, seen);
        e = sbq.pop_front();
        checks++;
        if (!seen || er !== e.err || lat !== e.lat || n_wr !== wr0) begin
            failures++; $display("FAIL timeout_rmw: seen %b err %b lat %0d writes %0d expected err 1 lat %0d writes 0",
                                 seen, er, lat, n_wr - wr0, e.lat);
        end
        tie0 = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        poke(32'h10, 32'h8899_AABB);
        poke(32'h14, 32'h0000_0000);
        poke(32'h18, 32'h1122_3344);
        poke(32'h20, 32'h7F00_807F);
        test_loads;
        test_stores;
        test_wait_states;
        test_back_to_back;
        test_reset_mid;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
